// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side, consumer-side and status signals of uart_rx_fifo
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic          rx_empty;
    logic [7:0]    rx_data;
    logic          uld_rx_data;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW:0]   level;
    logic          full;
    logic          ovf;
    logic          ovf_clr;
    logic          flush;
    logic          timeout;

    modport slave (
        input  rx_empty, rx_data, m_ready, ovf_clr, flush,
        output uld_rx_data, m_data, m_valid, level, full, ovf, timeout
    );

    modport master (
        output rx_empty, rx_data, m_ready, ovf_clr, flush,
        input  uld_rx_data, m_data, m_valid, level, full, ovf, timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive unload FSM feeding a FWFT byte FIFO
// Optional idle-data timeout enabled by UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 640
`endif
) (
    input logic           rxclk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_UNLD, ST_CAPT} state_t;

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    state_t        r_state;
    logic          r_uld;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_ovf;

    logic          w_full;
    logic          w_pop;
    logic          w_capt;
    logic          w_wr;
    logic          w_drop;

    assign w_full = (r_level == L_FULL);
    assign w_pop  = (r_level != '0) && bus.m_ready && !bus.flush;
    assign w_capt = (r_state == ST_CAPT) && !bus.flush;
    // A pop in the capture cycle frees the slot the incoming byte needs.
    assign w_wr   = w_capt && (!w_full || w_pop);
    assign w_drop = w_capt && w_full && !w_pop;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_uld   <= 1'b0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_uld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.rx_empty) begin
                        r_state <= ST_UNLD;
                        r_uld   <= 1'b1;
                    end
                end
                ST_UNLD: begin
                    r_state <= ST_CAPT;
                    r_uld   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_uld   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rxclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int              TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   L_TO = TW'(TIMEOUT_CYC);

    logic [TW-1:0] r_to_cnt;

    // Saturates at the limit so timeout holds until the next FIFO activity.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (bus.flush || w_wr || w_pop || (r_level == '0)) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != L_TO) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign bus.timeout = (r_to_cnt == L_TO);
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.uld_rx_data = r_uld;
    assign bus.m_data      = r_mem[r_rd_ptr];
    assign bus.m_valid     = (r_level != '0);
    assign bus.level       = r_level;
    assign bus.full        = w_full;
    assign bus.ovf         = r_ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
    localparam int DEPTH       = 16;
    localparam int TIMEOUT_CYC = 640;

    logic rxclk = 1'b0;
    logic reset = 1'b0;

    uart_rx_fifo_if #(.AW(4)) u_if ();

    uart_rx_fifo u_dut (
        .rxclk (rxclk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 rxclk = ~rxclk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".level"}, 32'(u_if.level), 32'(q.size()));
        check({tag, ".valid"}, 32'(u_if.m_valid), 32'(q.size() != 0));
        check({tag, ".full"},  32'(u_if.full), 32'(q.size() == DEPTH));
        check({tag, ".ovf"},   32'(u_if.ovf), 32'(m_ovf));
        if (q.size() != 0) check({tag, ".data"}, 32'(u_if.m_data), 32'(q[0]));
`ifndef UART_RX_FIFO_TIMEOUT_EN
        check({tag, ".timeout"}, 32'(u_if.timeout), 32'd0);
`endif
    endtask

    // mode: 0 plain, 1 pop during capture, 2 flush during capture, 3 ovf_clr during capture
    task automatic send_byte(input logic [7:0] b, input int mode);
        int lat = 0;
        logic drop;
        u_if.rx_data  = b;
        u_if.rx_empty = 1'b0;
        do begin
            tick();
            lat++;
        end while (!u_if.uld_rx_data && lat < 8);
        check("uld_latency", 32'(lat), 32'd1);
        u_if.rx_empty = 1'b1;
        tick();
        check("uld_one_cycle", 32'(u_if.uld_rx_data), 32'd0);
        if (mode == 1) begin
            u_if.m_ready = 1'b1;
            if (q.size() != 0) check("capt_pop_data", 32'(u_if.m_data), 32'(q[0]));
        end
        if (mode == 2) u_if.flush = 1'b1;
        if (mode == 3) u_if.ovf_clr = 1'b1;
        tick();
        u_if.m_ready = 1'b0;
        u_if.flush   = 1'b0;
        u_if.ovf_clr = 1'b0;
        if (mode == 2) begin
            q.delete();
        end else begin
            if (mode == 1 && q.size() != 0) void'(q.pop_front());
            drop = (q.size() >= DEPTH);
            if (drop) m_ovf = 1'b1;
            else begin
                q.push_back(b);
                if (mode == 3) m_ovf = 1'b0;
            end
        end
        check_state("send");
    endtask

    task automatic pop_one();
        u_if.m_ready = 1'b1;
        tick();
        u_if.m_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state("pop");
    endtask

    task automatic do_clr();
        u_if.ovf_clr = 1'b1;
        tick();
        u_if.ovf_clr = 1'b0;
        m_ovf = 1'b0;
        check_state("clr");
    endtask

    task automatic do_flush();
        u_if.flush = 1'b1;
        tick();
        u_if.flush = 1'b0;
        q.delete();
        check_state("flush");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        u_if.rx_empty = 1'b1;
        u_if.rx_data  = 8'h00;
        u_if.m_ready  = 1'b0;
        u_if.ovf_clr  = 1'b0;
        u_if.flush    = 1'b0;
        #3 reset = 1'b1;
        tick();
        tick();
        check("rst_uld", 32'(u_if.uld_rx_data), 32'd0);
        check_state("reset");
        reset = 1'b0;
        tick();

        // single byte with FWFT latency
        send_byte(8'hA5, 0);
        check("single_data", 32'(u_if.m_data), 32'hA5);
        pop_one();

        // fill past full, wraps the write pointer
        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 0);
        check("fill_ovf", 32'(u_if.ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_data", 32'(u_if.m_data), 32'(i));
            pop_one();
        end
        pop_one();

        // async reset while the unload strobe is high
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        u_if.rx_data  = 8'h33;
        u_if.rx_empty = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!u_if.uld_rx_data && lat < 8);
        check("rst_mid_uld_seen", 32'(u_if.uld_rx_data), 32'd1);
        #2 reset = 1'b1;
        #1;
        u_if.rx_empty = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        check("rst_mid_uld", 32'(u_if.uld_rx_data), 32'd0);
        check_state("rst_mid");
        tick();
        reset = 1'b0;
        tick();

        // full plus pop in the capture cycle: byte accepted, no overflow
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 0);
        send_byte(8'hE7, 1);
        check("full_pop_level", 32'(u_if.level), 32'd16);
        // overflow set wins over a same-cycle clear
        send_byte(8'h5A, 3);
        check("ovf_set_prio", 32'(u_if.ovf), 32'd1);
        do_clr();

        // flush with entries and a byte in capture
        send_byte(8'h99, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 0);
        do_flush();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 0);
        send_byte(8'h77, 2);
        check("flush_level", 32'(u_if.level), 32'd0);
        send_byte(8'h3C, 0);
        check("flush_next", 32'(u_if.m_data), 32'h3C);

        // idle-data timeout after the last write
        do_flush();
        send_byte(8'h81, 0);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
        check("timeout_early", 32'(u_if.timeout), 32'd0);
        tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        check("timeout_hit", 32'(u_if.timeout), 32'd1);
`else
        check("timeout_off", 32'(u_if.timeout), 32'd0);
`endif
        pop_one();
        check("timeout_pop", 32'(u_if.timeout), 32'd0);

        // randomized mix against the queue model
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 10) send_byte(8'($urandom), 0);
            else if (r < 11) send_byte(8'($urandom), 1);
            else if (r < 12) send_byte(8'($urandom), 3);
            else if (r < 13) send_byte(8'($urandom), 2);
            else if (r < 18) pop_one();
            else if (r < 19) do_clr();
            else do_flush();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
